if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the byte address of the first fetched instruction.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clk  in  1  sole clock; all state updates on rising edge
  rstn  in  1  asynchronous, active-low reset
  step_i  in  1  advance enable; the divided-clock strobe from the top level
  imem_addr_o  out  32  word address to instruction memory, equal to pc[31:2] zero-extended
  imem_data_i  in  32  combinational instruction read data, valid in the same cycle
  redirect_i  in  1  branch/jump taken; overrides fetch
  redirect_pc_i  in  32  byte target for redirect_i
  id_valid_o  out  1  instruction register holds a valid instruction
  id_ready_i  in  1  decode stage accepts id_inst_o/id_pc_o this cycle
  id_inst_o  out  32  fetched instruction
  id_pc_o  out  32  byte PC of id_inst_o
  pc_o  out  32  current fetch PC (byte address), for display
  halted_o  out  1  state is HALT
  err_o  out  1  state is ERR (misaligned redirect)
  fetch_cnt_o  out  16  number of fetches performed, wraps modulo 2^16

Function
REQ-003 The block SHALL have 3 states: RUN, HALT and ERR.
REQ-004 The outregister is free when id_valid_o=0, or when id_valid_o=1 and id_ready_i=1.
REQ-005 A fetch SHALL occur when state=RUN, step_i=1, redirect_i=0 and the output register is free.
REQ-006 On a fetch, the block SHALL load id_inst_o<=imem_data_i, load id_pc_o<=pc, set id_valid_o<=1, set pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and increment fetch_cnt_o (wrapping).
REQ-007 When id_valid_o=1 and id_ready_i=1 without a fetch, the block SHALL set id_valid_o<=0.
REQ-008 When id_valid_o=1 and id_ready_i=0, id_inst_o and id_pc_o SHALL hold their values, and the pc SHALL hold its value.
REQ-009 Handling of redirect_i=1, which takes priority over fetch and step_i and is evaluated in any state other than ERR:
  - The block SHALL flush, setting id_valid_o<=0.
  - The block SHALL not fetch in that cycle.
  - If redirect_pc_i[1:0]=2'b00, the block SHALL set pc<=redirect_pc_i and state<=RUN; this also exits HALT.
  - If redirect_pc_i[1:0]!=2'b00, the pc SHALL be unchanged and state SHALL go to ERR.
REQ-010 On the fetch of imem_data_i=32'h0010_0073 (EBREAK), the instruction SHALL be captured normally, and state SHALL go from RUN to HALT on the same edge.
REQ-011 In HALT, no fetches SHALL occur, and a pending id_valid_o SHALL still drain per REQ-007.
REQ-012 ERR SHALL be left only by reset, and in ERR redirect_i and step_i SHALL be ignored while draining continues per REQ-007.
REQ-013 imem_addr_o and pc_o SHALL be combinational from the pc register; fetch latency is 1 edge from qualifying step_i to id_valid_o=1.
REQ-014 halted_o SHALL be 1 exactly when state=HALT, and err_o SHALL be 1 exactly when state=ERR.
REQ-015 When step_i=0, the pc SHALL hold, no fetch SHALL occur, and draining and redirect SHALL still act.

Reset
REQ-016 While rstn=0, regardless of clk, the block SHALL force:
  - pc=RESET_PC
  - id_valid_o=0
  - id_inst_o=32'h0000_0013 (NOP)
  - id_pc_o=0
  - fetch_cnt_o=0
  - state=RUN, so halted_o=0 and err_o=0
REQ-017 A reset asserted mid-operation SHALL discard any held instruction, and the first fetch after rstn deasserts SHALL read RESET_PC.

Verification
REQ-018 Sequential fetch: id_ready_i=1, step_i=1 every cycle, memory word n = n -> id_inst_o sequence 0,1,2,..., id_pc_o 0,4,8,..., fetch_cnt_o increments by 1 per cycle.
REQ-019 Backpressure: id_ready_i=0 for 3 cycles with id_valid_o=1 -> id_inst_o/id_pc_o/pc stable for 3 cycles and fetch_cnt_o unchanged; after id_ready_i=1, the next fetch occurs on the following edge.
REQ-020 Redirect: redirect_i=1, redirect_pc_i=32'h40 in the same cycle as a qualifying step -> id_valid_o=0 next cycle, pc_o=32'h40, and the next fetch gives id_pc_o=32'h40.
REQ-021 EBREAK: memory word 2 = 32'h0010_0073 -> id_inst_o=32'h0010_0073 and halted_o=1 on the same edge, with no further fetches; then redirect to 32'h0 -> halted_o=0 and fetching resumes at 0.
REQ-022 Misaligned redirect: redirect_pc_i=32'h42 -> err_o=1, pc unchanged, and later redirects/steps ignored; rstn pulse -> err_o=0, pc_o=RESET_PC.
REQ-023 Wrap: RESET_PC=32'hFFFF_FFFC -> the first fetch has id_pc_o=32'hFFFF_FFFC and the second has id_pc_o=32'h0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, a one-entry output register toward decode, and a
// RUN/HALT/ERR state machine covering EBREAK halts and misaligned redirect targets.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        step_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] pc_o,
    output logic        halted_o,
    output logic        err_o,
    output logic [15:0] fetch_cnt_o
);

    localparam logic [31:0] Nop    = 32'h0000_0013;
    localparam logic [31:0] Ebreak = 32'h0010_0073;

    typedef enum logic [1:0] {
        StRun,
        StHalt,
        StErr
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc_q;
    logic [15:0] fetch_cnt_q;

    logic out_free;
    logic redirect_act;
    logic fetch;

    // The output register frees up in the same cycle decode takes its contents.
    assign out_free     = !id_valid_q || id_ready_i;
    assign redirect_act = redirect_i && (state_q != StErr);
    assign fetch        = (state_q == StRun) && step_i && !redirect_i && out_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_inst_q   <= Nop;
            id_pc_q     <= 32'h0;
            fetch_cnt_q <= 16'h0;
        end else if (redirect_act) begin
            id_valid_q <= 1'b0;
            if (redirect_pc_i[1:0] == 2'b00) begin
                pc_q    <= redirect_pc_i;
                state_q <= StRun;
            end else begin
                state_q <= StErr;
            end
        end else if (fetch) begin
            id_inst_q   <= imem_data_i;
            id_pc_q     <= pc_q;
            id_valid_q  <= 1'b1;
            pc_q        <= pc_q + 32'd4;
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (imem_data_i == Ebreak) begin
                state_q <= StHalt;
            end
        end else if (id_valid_q && id_ready_i) begin
            id_valid_q <= 1'b0;
        end
    end

    assign imem_addr_o = {2'b00, pc_q[31:2]};
    assign pc_o        = pc_q;
    assign id_valid_o  = id_valid_q;
    assign id_inst_o   = id_inst_q;
    assign id_pc_o     = id_pc_q;
    assign fetch_cnt_o = fetch_cnt_q;
    assign halted_o    = (state_q == StHalt);
    assign err_o       = (state_q == StErr);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, backpressure, redirect, EBREAK halt,
// misaligned redirect error, mid-operation reset and PC wrap-around.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        step;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] pc;
    logic        halted;
    logic        err;
    logic [15:0] fetch_cnt;

    logic        step_w;
    logic [31:0] imem_addr_w;
    logic        id_valid_w;
    logic [31:0] id_inst_w;
    logic [31:0] id_pc_w;
    logic [31:0] pc_w;
    logic        halted_w;
    logic        err_w;
    logic [15:0] fetch_cnt_w;

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[5:0]];

    if_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .step_i       (step),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .id_valid_o   (id_valid),
        .id_ready_i   (id_ready),
        .id_inst_o    (id_inst),
        .id_pc_o      (id_pc),
        .pc_o         (pc),
        .halted_o     (halted),
        .err_o        (err),
        .fetch_cnt_o  (fetch_cnt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk          (clk),
        .rstn         (rstn),
        .step_i       (step_w),
        .imem_addr_o  (imem_addr_w),
        .imem_data_i  (32'h0000_00A5),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
        .id_valid_o   (id_valid_w),
        .id_ready_i   (1'b1),
        .id_inst_o    (id_inst_w),
        .id_pc_o      (id_pc_w),
        .pc_o         (pc_w),
        .halted_o     (halted_w),
        .err_o        (err_w),
        .fetch_cnt_o  (fetch_cnt_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i;
        rstn        = 1'b0;
        step        = 1'b0;
        step_w      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        #12;

        // Reset state
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_inst", id_inst, 32'h0000_0013);
        chk("rst_idpc", id_pc, 32'h0);
        chk("rst_cnt", {16'h0, fetch_cnt}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_halt", {31'h0, halted}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // Sequential fetch
        tick();
        rstn = 1'b1;
        step = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("seq_valid", {31'h0, id_valid}, 32'h1);
            chk("seq_inst", id_inst, n);
            chk("seq_idpc", id_pc, 4 * n);
            chk("seq_cnt", {16'h0, fetch_cnt}, n + 1);
        end
        chk("seq_pc", pc, 32'd16);
        chk("seq_addr", imem_addr, 32'd4);

        // Backpressure
        id_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("bp_valid", {31'h0, id_valid}, 32'h1);
            chk("bp_inst", id_inst, 32'd3);
            chk("bp_idpc", id_pc, 32'd12);
            chk("bp_pc", pc, 32'd16);
            chk("bp_cnt", {16'h0, fetch_cnt}, 32'd4);
        end
        id_ready = 1'b1;
        tick();
        chk("bp_rel_inst", id_inst, 32'd4);
        chk("bp_rel_idpc", id_pc, 32'd16);
        chk("bp_rel_cnt", {16'h0, fetch_cnt}, 32'd5);

        // Redirect alongside a qualifying step
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("rd_valid", {31'h0, id_valid}, 32'h0);
        chk("rd_pc", pc, 32'h40);
        chk("rd_addr", imem_addr, 32'h10);
        chk("rd_cnt", {16'h0, fetch_cnt}, 32'd5);
        tick();
        chk("rd_fetch_idpc", id_pc, 32'h40);
        chk("rd_fetch_inst", id_inst, 32'd16);
        chk("rd_fetch_cnt", {16'h0, fetch_cnt}, 32'd6);

        // step_i low: drain still happens, pc holds
        step = 1'b0;
        tick();
        chk("nostep_valid", {31'h0, id_valid}, 32'h0);
        chk("nostep_pc", pc, 32'h44);
        chk("nostep_cnt", {16'h0, fetch_cnt}, 32'd6);

        // EBREAK at word 2
        mem[2]      = 32'h0010_0073;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        step     = 1'b1;
        tick();
        tick();
        chk("eb_pre_halt", {31'h0, halted}, 32'h0);
        tick();
        chk("eb_inst", id_inst, 32'h0010_0073);
        chk("eb_idpc", id_pc, 32'd8);
        chk("eb_halt", {31'h0, halted}, 32'h1);
        chk("eb_cnt", {16'h0, fetch_cnt}, 32'd9);
        tick();
        chk("halt_drain", {31'h0, id_valid}, 32'h0);
        chk("halt_pc", pc, 32'd12);
        chk("halt_cnt", {16'h0, fetch_cnt}, 32'd9);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        chk("unhalt", {31'h0, halted}, 32'h0);
        chk("unhalt_pc", pc, 32'h0);
        tick();
        chk("resume_idpc", id_pc, 32'h0);
        chk("resume_cnt", {16'h0, fetch_cnt}, 32'd10);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        tick();
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_pc", pc, 32'd4);
        chk("mis_valid", {31'h0, id_valid}, 32'h0);
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        tick();
        chk("err_stuck", {31'h0, err}, 32'h1);
        chk("err_pc", pc, 32'd4);
        chk("err_cnt", {16'h0, fetch_cnt}, 32'd10);
        rstn = 1'b0;
        #2;
        chk("err_rst", {31'h0, err}, 32'h0);
        chk("err_rst_pc", pc, 32'h0);
        tick();
        rstn = 1'b1;

        // Reset mid-operation discards a held instruction
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        chk("held_valid", {31'h0, id_valid}, 32'h1);
        rstn = 1'b0;
        #2;
        chk("mid_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("mid_rst_inst", id_inst, 32'h0000_0013);
        tick();
        rstn     = 1'b1;
        id_ready = 1'b1;
        tick();
        chk("post_rst_idpc", id_pc, 32'h0);
        chk("post_rst_inst", id_inst, 32'h0);

        // PC wrap on the second instance
        step   = 1'b0;
        step_w = 1'b1;
        tick();
        chk("wrap_first", id_pc_w, 32'hFFFF_FFFC);
        chk("wrap_pc", pc_w, 32'h0);
        tick();
        chk("wrap_second", id_pc_w, 32'h0);
        chk("wrap_cnt", {16'h0, fetch_cnt_w}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
